// File: rtl/mult_accumulator_if.sv
// Operand/result bus of the multiply-accumulate stage. The master side drives operand beats
// and accepts results; the slave side is the accumulator itself.
interface mult_accumulator_if #(
  parameter int SIZE  = 10,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) ();
  // Valid/ready: a transfer occurs on a rising edge where valid and ready are both high;
  // valid never waits for ready, and payload is held stable while valid is high and ready low.
  logic             i_valid;
  logic             o_ready;
  logic [SIZE-1:0]  i_A;
  logic [SIZE-1:0]  i_B;
  logic [LEN_W-1:0] i_len;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_acc;
  logic [LEN_W-1:0] o_count;
  logic             o_ovf;
  logic [1:0]       o_state;

  modport slave (
    input  i_valid, i_A, i_B, i_len, i_ready,
    output o_ready, o_valid, o_acc, o_count, o_ovf, o_state
  );

  modport master (
    output i_valid, i_A, i_B, i_len, i_ready,
    input  o_ready, o_valid, o_acc, o_count, o_ovf, o_state
  );
endinterface

// File: rtl/mult_accumulator.sv
// Sequential MAC stage: registers operand pairs, multiplies them with an array multiplier and
// sums i_len products per block. Define MULT_ACC_SAT_EN to saturate instead of wrap on overflow.

module array_multiplier #(
  parameter int SIZE = 10
) (
  input  logic [SIZE-1:0]   i_a,
  input  logic [SIZE-1:0]   i_b,
  output logic [2*SIZE-1:0] o_p
);
  // Row i adds the partial product a & b[i], shifted into position, onto the running sum.
  logic [2*SIZE-1:0] w_row [0:SIZE];

  assign w_row[0] = '0;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    logic [2*SIZE-1:0] w_pp;
    assign w_pp          = {{SIZE{1'b0}}, (i_a & {SIZE{i_b[gi]}})} << gi;
    assign w_row[gi + 1] = w_row[gi] + w_pp;
  end

  assign o_p = w_row[SIZE];
endmodule

module mult_accumulator #(
  parameter int SIZE  = 10,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  mult_accumulator_if.slave   bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_rem;
  logic               r_valid;
  logic [SIZE-1:0]    r_a;
  logic [SIZE-1:0]    r_b;
  logic               r_v1;
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_ready;
  logic               w_accept;
  logic               w_first;
  logic [LEN_W-1:0]   w_len_eff;
  logic [2*SIZE-1:0]  w_prod;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_next;

  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  // A beat offered alongside i_clear is dropped.
  assign w_accept  = bus.i_valid && w_ready && !i_clear;
  assign w_first   = w_accept && (r_state == ST_IDLE);
  assign w_len_eff = (bus.i_len == '0) ? LEN_W'(1) : bus.i_len;

  array_multiplier #(.SIZE(SIZE)) u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
  assign w_carry = w_sum[ACC_W];

`ifdef MULT_ACC_SAT_EN
  // Once a block has overflowed the sum stays pinned at full scale.
  assign w_acc_next = (w_carry || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rem   <= w_len_eff - LEN_W'(1);
            r_state <= (w_len_eff > LEN_W'(1)) ? ST_ACCUM : ST_DRAIN;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_HOLD;
          r_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (bus.i_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // The first beat of a block clears the previous result; the previous block's last product
  // was already absorbed during DRAIN, so r_v1 is low here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_v1    <= 1'b0;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_v1    <= 1'b0;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a <= bus.i_A;
        r_b <= bus.i_B;
      end
      if (w_first) begin
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (r_v1) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + LEN_W'(1);
        if (w_carry) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_acc   = r_acc;
  assign bus.o_count = r_count;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_state = r_state;
endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: a 32-bit accumulator instance plus a 20-bit one
// sharing the same stimulus to exercise overflow.
module tb_mult_accumulator;
  logic clk;
  logic rst_n;
  logic clear;
  int   n_tests;
  int   n_fail;

  mult_accumulator_if #(.SIZE(10), .ACC_W(32), .LEN_W(8)) bus ();
  mult_accumulator_if #(.SIZE(10), .ACC_W(20), .LEN_W(8)) bus20 ();

  assign bus20.i_valid = bus.i_valid;
  assign bus20.i_A     = bus.i_A;
  assign bus20.i_B     = bus.i_B;
  assign bus20.i_len   = bus.i_len;
  assign bus20.i_ready = bus.i_ready;

  mult_accumulator #(.SIZE(10), .ACC_W(32), .LEN_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus)
  );

  mult_accumulator #(.SIZE(10), .ACC_W(20), .LEN_W(8)) dut20 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus20)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: present one beat for exactly one edge
  task automatic beat(input logic [9:0] a, input logic [9:0] b, input logic [7:0] len);
    bus.i_valid = 1'b1;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_len   = len;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic take_result(input string tag);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check({tag, "_valid_low"}, bus.o_valid, 1'b0);
    check({tag, "_ready_high"}, bus.o_ready, 1'b1);
  endtask

  logic [19:0] exp_ovf_acc;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    bus.i_len   = '0;
    bus.i_ready = 1'b0;
`ifdef MULT_ACC_SAT_EN
    exp_ovf_acc = 20'd1048575;
`else
    exp_ovf_acc = 20'd1044482;
`endif

    // reset state
    #12;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_acc",   bus.o_acc,   32'd0);
    check("rst_count", bus.o_count, 8'd0);
    check("rst_ovf",   bus.o_ovf,   1'b0);
    check("rst_ready", bus.o_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // 1: len=3 back-to-back, 2*3+4*5+6*7 = 68, result two cycles after last beat
    beat(10'd2, 10'd3, 8'd3);
    beat(10'd4, 10'd5, 8'd3);
    beat(10'd6, 10'd7, 8'd3);
    check("t1_drain_valid", bus.o_valid, 1'b0);
    check("t1_drain_ready", bus.o_ready, 1'b0);
    step();
    check("t1_valid", bus.o_valid, 1'b1);
    check("t1_acc",   bus.o_acc,   32'd68);
    check("t1_count", bus.o_count, 8'd3);
    check("t1_ovf",   bus.o_ovf,   1'b0);
    take_result("t1");
    check("t1_persist_acc", bus.o_acc, 32'd68);

    // 2: len=0 acts as len=1; a beat offered during DRAIN/HOLD waits for the handshake
    beat(10'd1023, 10'd1023, 8'd0);
    bus.i_valid = 1'b1;
    bus.i_A     = 10'd7;
    bus.i_B     = 10'd7;
    bus.i_len   = 8'd1;
    step();
    check("t2_valid", bus.o_valid, 1'b1);
    check("t2_acc",   bus.o_acc,   32'd1046529);
    check("t2_count", bus.o_count, 8'd1);
    check("t2_ready", bus.o_ready, 1'b0);
    step();
    check("t2_hold_acc", bus.o_acc, 32'd1046529);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check("t2_hs_valid", bus.o_valid, 1'b0);
    check("t2_hs_acc",   bus.o_acc,   32'd1046529);
    step();
    bus.i_valid = 1'b0;
    step();
    check("t2_next_valid", bus.o_valid, 1'b1);
    check("t2_next_acc",   bus.o_acc,   32'd49);
    check("t2_next_count", bus.o_count, 8'd1);
    take_result("t2");

    // 3: len=4 gapped beats (i,50-i): 0+49+96+141 = 286, then a long stall
    for (int i = 0; i < 4; i++) begin
      beat(10'(i), 10'(50 - i), 8'd4);
      if (i < 3) step();
    end
    step();
    check("t3_acc",   bus.o_acc,   32'd286);
    check("t3_count", bus.o_count, 8'd4);
    bus.i_valid = 1'b1;
    bus.i_A     = 10'd9;
    bus.i_B     = 10'd9;
    bus.i_len   = 8'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_stall_valid", bus.o_valid, 1'b1);
      check("t3_stall_acc",   bus.o_acc,   32'd286);
      check("t3_stall_ready", bus.o_ready, 1'b0);
    end
    bus.i_valid = 1'b0;
    take_result("t3");
    check("t3_after_count", bus.o_count, 8'd4);

    // 4: overflow, (1023*1023)*2 = 2093058 exceeds 20 bits
    beat(10'd1023, 10'd1023, 8'd2);
    beat(10'd1023, 10'd1023, 8'd2);
    step();
    check("t4_acc20",  bus20.o_acc, exp_ovf_acc);
    check("t4_ovf20",  bus20.o_ovf, 1'b1);
    check("t4_acc32",  bus.o_acc,   32'd2093058);
    check("t4_ovf32",  bus.o_ovf,   1'b0);
    take_result("t4");
    check("t4_ovf_sticky", bus20.o_ovf, 1'b1);
    beat(10'd1, 10'd1, 8'd1);
    step();
    check("t4_next_acc20", bus20.o_acc, 20'd1);
    check("t4_next_ovf20", bus20.o_ovf, 1'b0);
    take_result("t4n");

    // 5: clear after two beats of a len=4 block; a beat offered with clear is dropped
    beat(10'd10, 10'd10, 8'd4);
    beat(10'd20, 10'd20, 8'd4);
    clear       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_A     = 10'd30;
    bus.i_B     = 10'd30;
    step();
    clear       = 1'b0;
    bus.i_valid = 1'b0;
    check("t5_state", bus.o_state, 2'd0);
    check("t5_acc",   bus.o_acc,   32'd0);
    check("t5_count", bus.o_count, 8'd0);
    check("t5_valid", bus.o_valid, 1'b0);
    check("t5_ready", bus.o_ready, 1'b1);
    step();
    check("t5_idle_acc", bus.o_acc, 32'd0);
    beat(10'd5, 10'd5, 8'd1);
    step();
    check("t5_acc25",   bus.o_acc,   32'd25);
    check("t5_count25", bus.o_count, 8'd1);
    take_result("t5");

    // 6: asynchronous reset mid-ACCUM, between clock edges
    beat(10'd10, 10'd10, 8'd4);
    beat(10'd20, 10'd20, 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_acc",   bus.o_acc,   32'd0);
    check("t6_count", bus.o_count, 8'd0);
    check("t6_valid", bus.o_valid, 1'b0);
    check("t6_ovf",   bus.o_ovf,   1'b0);
    check("t6_ready", bus.o_ready, 1'b1);
    #3;
    rst_n = 1'b1;
    step();
    beat(10'd3, 10'd3, 8'd1);
    step();
    check("t6_acc9",   bus.o_acc,   32'd9);
    check("t6_count9", bus.o_count, 8'd1);
    take_result("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
